// File: rtl/cache_params_pkg.sv
// Shared geometry of the direct-mapped cache and the CPU request payload.
package CacheParams;
    localparam int unsigned ADDR_WIDTH  = 8;
    localparam int unsigned DATA_WIDTH  = 8;
    localparam int unsigned LINE_SIZE   = 4;
    localparam int unsigned NUM_LINES   = 4;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_SIZE);
    localparam int unsigned IDX_BITS    = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS    = ADDR_WIDTH - IDX_BITS - OFFSET_BITS;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wrData;
    } CpuReq;
endpackage

// File: rtl/cache_controller_if.sv
// CPU, cache-array and memory signals of the cache controller.
interface cache_controller_if;
    import CacheParams::*;

    logic                  CpuReqVal;
    logic                  CpuReqRdy;
    logic                  CpuReqWr;
    logic [ADDR_WIDTH-1:0] CpuReqAddr;
    logic [DATA_WIDTH-1:0] CpuReqWrData;
    logic                  CpuRspVal;
    logic [DATA_WIDTH-1:0] CpuRspData;

    logic [ADDR_WIDTH-1:0] CacheAddr;
    logic                  CacheAddrVal;
    logic [DATA_WIDTH-1:0] CacheWrData;
    logic                  CacheReplaceEn;
    logic                  CacheWrEn;
    logic                  CacheRst;
    logic [DATA_WIDTH-1:0] CacheRdData;
    logic                  CacheHit;
    logic                  CacheDirty;
    logic [TAG_BITS-1:0]   CacheVictimTag;

    logic                  MemReqVal;
    logic                  MemReqRdy;
    logic                  MemReqWr;
    logic [ADDR_WIDTH-1:0] MemReqAddr;
    logic [DATA_WIDTH-1:0] MemReqWrData;
    logic                  MemRspVal;
    logic [DATA_WIDTH-1:0] MemRspData;

    // Controller side
    modport master (
        input  CpuReqVal, CpuReqWr, CpuReqAddr, CpuReqWrData,
        output CpuReqRdy, CpuRspVal, CpuRspData,
        output CacheAddr, CacheAddrVal, CacheWrData, CacheReplaceEn, CacheWrEn, CacheRst,
        input  CacheRdData, CacheHit, CacheDirty, CacheVictimTag,
        output MemReqVal, MemReqWr, MemReqAddr, MemReqWrData,
        input  MemReqRdy, MemRspVal, MemRspData
    );

    // Environment side (CPU, cache array, memory)
    modport slave (
        output CpuReqVal, CpuReqWr, CpuReqAddr, CpuReqWrData,
        input  CpuReqRdy, CpuRspVal, CpuRspData,
        input  CacheAddr, CacheAddrVal, CacheWrData, CacheReplaceEn, CacheWrEn, CacheRst,
        output CacheRdData, CacheHit, CacheDirty, CacheVictimTag,
        input  MemReqVal, MemReqWr, MemReqAddr, MemReqWrData,
        output MemReqRdy, MemRspVal, MemRspData
    );
endinterface

// File: rtl/cache_controller.sv
// Write-back, write-allocate controller for a direct-mapped cache with a
// word-granular memory port. Sweeps the tag array after reset, then serves
// one CPU request at a time: lookup, optional victim write-back, refill, replay.
module cache_controller
    import CacheParams::*;
(
    input  logic               Clk,
    input  logic               RstN,
    cache_controller_if.master bus
);
    typedef enum logic [2:0] {
        INIT, IDLE, LOOKUP, WB, REFILL_REQ, REFILL_WAIT, RESP
    } CtrlState;

    localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(LINE_SIZE - 1);
    localparam logic [IDX_BITS-1:0]    LAST_LINE = IDX_BITS'(NUM_LINES - 1);

    CtrlState               state, stateNext;
    CpuReq                  req, reqNext;
    logic [TAG_BITS-1:0]    victimTag, victimTagNext;
    logic [OFFSET_BITS-1:0] wordCnt, wordCntNext;
    logic [IDX_BITS-1:0]    sweepCnt, sweepCntNext;
    logic [DATA_WIDTH-1:0]  rspData, rspDataNext;
    logic                   sweepOn;

    logic [TAG_BITS-1:0]    reqTag;
    logic [IDX_BITS-1:0]    reqIdx;

    assign reqTag         = req.addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign reqIdx         = req.addr[OFFSET_BITS +: IDX_BITS];
    assign bus.CpuRspData = rspData;

    // State and datapath registers; sweepOn keeps CacheRst low until the first clock after reset
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state     <= INIT;
            req       <= '0;
            victimTag <= '0;
            wordCnt   <= '0;
            sweepCnt  <= '0;
            rspData   <= '0;
            sweepOn   <= 1'b0;
        end else begin
            state     <= stateNext;
            req       <= reqNext;
            victimTag <= victimTagNext;
            wordCnt   <= wordCntNext;
            sweepCnt  <= sweepCntNext;
            rspData   <= rspDataNext;
            sweepOn   <= (stateNext == INIT);
        end
    end

    // Next-state, counter updates and per-state outputs
    always_comb begin
        stateNext          = state;
        reqNext            = req;
        victimTagNext      = victimTag;
        wordCntNext        = wordCnt;
        sweepCntNext       = sweepCnt;
        rspDataNext        = rspData;
        bus.CpuReqRdy      = 1'b0;
        bus.CpuRspVal      = 1'b0;
        bus.CacheAddr      = '0;
        bus.CacheAddrVal   = 1'b0;
        bus.CacheWrData    = '0;
        bus.CacheReplaceEn = 1'b0;
        bus.CacheWrEn      = 1'b0;
        bus.CacheRst       = 1'b0;
        bus.MemReqVal      = 1'b0;
        bus.MemReqWr       = 1'b0;
        bus.MemReqAddr     = '0;
        bus.MemReqWrData   = '0;

        case (state)
            INIT: begin
                bus.CacheRst  = sweepOn;
                bus.CacheAddr = {TAG_BITS'(0), sweepCnt, OFFSET_BITS'(0)};
                if (sweepOn) begin
                    if (sweepCnt == LAST_LINE) begin
                        sweepCntNext = '0;
                        stateNext    = IDLE;
                    end else begin
                        sweepCntNext = sweepCnt + IDX_BITS'(1);
                    end
                end
            end
            IDLE: begin
                bus.CpuReqRdy = 1'b1;
                if (bus.CpuReqVal) begin
                    reqNext.wr     = bus.CpuReqWr;
                    reqNext.addr   = bus.CpuReqAddr;
                    reqNext.wrData = bus.CpuReqWrData;
                    stateNext      = LOOKUP;
                end
            end
            LOOKUP: begin
                bus.CacheAddr    = req.addr;
                bus.CacheAddrVal = 1'b1;
                victimTagNext    = bus.CacheVictimTag;
                if (bus.CacheHit) begin
                    if (req.wr) begin
                        bus.CacheWrEn   = 1'b1;
                        bus.CacheWrData = req.wrData;
                    end else begin
                        rspDataNext = bus.CacheRdData;
                    end
                    stateNext = RESP;
                end else begin
                    wordCntNext = '0;
                    stateNext   = bus.CacheDirty ? WB : REFILL_REQ;
                end
            end
            WB: begin
                bus.MemReqVal    = 1'b1;
                bus.MemReqWr     = 1'b1;
                bus.MemReqAddr   = {victimTag, reqIdx, wordCnt};
                bus.CacheAddr    = {reqTag, reqIdx, wordCnt};
                bus.MemReqWrData = bus.CacheRdData;
                if (bus.MemReqRdy) begin
                    if (wordCnt == LAST_WORD) begin
                        wordCntNext = '0;
                        stateNext   = REFILL_REQ;
                    end else begin
                        wordCntNext = wordCnt + OFFSET_BITS'(1);
                    end
                end
            end
            REFILL_REQ: begin
                bus.MemReqVal  = 1'b1;
                bus.MemReqAddr = {reqTag, reqIdx, wordCnt};
                if (bus.MemReqRdy) begin
                    stateNext = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (bus.MemRspVal) begin
                    bus.CacheAddr      = {reqTag, reqIdx, wordCnt};
                    bus.CacheAddrVal   = 1'b1;
                    bus.CacheReplaceEn = 1'b1;
                    bus.CacheWrData    = bus.MemRspData;
                    if (wordCnt == LAST_WORD) begin
                        wordCntNext = '0;
                        stateNext   = LOOKUP;
                    end else begin
                        wordCntNext = wordCnt + OFFSET_BITS'(1);
                        stateNext   = REFILL_REQ;
                    end
                end
            end
            RESP: begin
                bus.CpuRspVal = 1'b1;
                stateNext     = IDLE;
            end
            default: begin
                stateNext = INIT;
            end
        endcase
    end
endmodule
